// File: rtl/dctq_pkg.sv
// Shared types and constants for the DCTQ frame controller: FSM state encoding,
// block geometry and default datapath widths.
package dctq_pkg;

  localparam int BLK_COEFS    = 64;
  localparam int LAST_ADDR    = BLK_COEFS - 1;
  localparam int DEF_NUM_BLKS = 1024;
  localparam int DEF_ROW_W    = 64;
  localparam int DEF_COEF_W   = 9;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    WAIT_RDY,
    START,
    DRAIN,
    DONE
  } state_t;

endpackage

// File: rtl/dctq_coef_stage.sv
// Coefficient output register with combinational backpressure, completed-block count
// and, when DCTQ_FRAME_CTRL_NZCNT_EN is defined, a per-block nonzero-coefficient counter.
module dctq_coef_stage
  import dctq_pkg::*;
#(
  parameter int NUM_BLKS = DEF_NUM_BLKS,
  parameter int COEF_W   = DEF_COEF_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              frame_clr,
  input  logic [COEF_W-1:0] dctq,
  input  logic              dctq_valid,
  input  logic [5:0]        addr,
  input  logic              sink_ready,
  output logic [COEF_W-1:0] coef_out,
  output logic              coef_valid,
  output logic              coef_last,
  output logic              hold,
  output logic [10:0]       blk_cnt,
  output logic              frame_full
`ifdef DCTQ_FRAME_CTRL_NZCNT_EN
  ,
  output logic [6:0]        nz_cnt,
  output logic              nz_valid
`endif
);

  localparam logic [10:0] BLK_MAX  = 11'(NUM_BLKS);
  localparam logic [5:0]  LAST_IDX = 6'(LAST_ADDR);

  logic accept;
  logic accept_last;
  logic suppress;

  assign hold        = coef_valid && !sink_ready;
  assign accept      = coef_valid && sink_ready;
  assign accept_last = accept && coef_last;
  assign frame_full  = (blk_cnt == BLK_MAX);
  // Also block the cycle in which the final block is being accepted, so nothing slips in behind it.
  assign suppress    = frame_full || (accept_last && (blk_cnt == BLK_MAX - 11'd1));

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      coef_out   <= '0;
      coef_valid <= 1'b0;
      coef_last  <= 1'b0;
    end else if (!hold) begin
      coef_out   <= dctq;
      coef_valid <= dctq_valid && !suppress;
      coef_last  <= dctq_valid && !suppress && (addr == LAST_IDX);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      blk_cnt <= '0;
    end else if (frame_clr) begin
      blk_cnt <= '0;
    end else if (accept_last && !frame_full) begin
      blk_cnt <= blk_cnt + 11'd1;
    end
  end

`ifdef DCTQ_FRAME_CTRL_NZCNT_EN
  logic [6:0] nz_acc;
  logic [6:0] nz_hit;

  assign nz_hit = (coef_out != '0) ? 7'd1 : 7'd0;

  // The accumulator restarts per block; nz_cnt is shown for one cycle then cleared.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      nz_acc   <= '0;
      nz_cnt   <= '0;
      nz_valid <= 1'b0;
    end else begin
      nz_valid <= 1'b0;
      if (nz_valid) nz_cnt <= '0;
      if (frame_clr) begin
        nz_acc <= '0;
      end else if (accept_last) begin
        nz_cnt   <= nz_acc + nz_hit;
        nz_valid <= 1'b1;
        nz_acc   <= '0;
      end else if (accept) begin
        nz_acc <= nz_acc + nz_hit;
      end
    end
  end
`endif

endmodule

// File: rtl/dctq_frame_ctrl.sv
// Frame controller: streams block rows from frame memory into the DCTQ core and forwards
// its coefficients. Optional nonzero counter enabled by DCTQ_FRAME_CTRL_NZCNT_EN.
module dctq_frame_ctrl
  import dctq_pkg::*;
#(
  parameter int NUM_BLKS = DEF_NUM_BLKS,
  parameter int ROW_W    = DEF_ROW_W,
  parameter int ROWS     = 8,
  parameter int COEF_W   = DEF_COEF_W,
  parameter int ADDR_W   = 13
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              frame_start,
  output logic              mem_rd,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [ROW_W-1:0]  mem_rdata,
  output logic [ROW_W-1:0]  di,
  output logic              din_valid,
  output logic [2:0]        wa,
  input  logic              ready,
  output logic              start,
  output logic              hold,
  input  logic [COEF_W-1:0] dctq,
  input  logic              dctq_valid,
  input  logic [5:0]        addr,
  output logic [COEF_W-1:0] coef_out,
  output logic              coef_valid,
  output logic              coef_last,
  input  logic              sink_ready,
  output logic [10:0]       blk_cnt,
  output logic              busy,
  output logic              frame_done
`ifdef DCTQ_FRAME_CTRL_NZCNT_EN
  ,
  output logic [6:0]        nz_cnt,
  output logic              nz_valid
`endif
);

  localparam int ROW_IDX_W = (ROWS > 1) ? $clog2(ROWS) : 1;
  localparam int ISSUE_W   = $clog2(NUM_BLKS + 1);
  localparam logic [ROW_IDX_W-1:0] LAST_ROW  = ROW_IDX_W'(ROWS - 1);
  localparam logic [ISSUE_W-1:0]   ISSUE_MAX = ISSUE_W'(NUM_BLKS);

  // A frame must fit the address space without wrapping onto itself, and blk_cnt is 11 bits.
  if ((ROWS * NUM_BLKS > (1 << ADDR_W)) || (NUM_BLKS > 2047)) begin : g_cfg_check
    $error("dctq_frame_ctrl: ROWS*NUM_BLKS exceeds 2**ADDR_W or NUM_BLKS exceeds blk_cnt range");
  end

  state_t                 state;
  state_t                 state_nxt;
  logic [ROW_IDX_W-1:0]   row_cnt;
  logic [ISSUE_W-1:0]     issue_cnt;
  logic                   frame_clr;
  logic                   last_row;
  logic                   frame_full;

  assign frame_clr = (state == IDLE) && frame_start;
  assign last_row  = (row_cnt == LAST_ROW);
  assign busy      = (state != IDLE);

  // NOTE: the asynchronous reset appears in the sensitivity list so it acts without a clock edge.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  // NOTE: every output of this block is defaulted first so no path can infer a latch.
  always_comb begin
    state_nxt  = state;
    mem_rd     = 1'b0;
    start      = 1'b0;
    frame_done = 1'b0;
    case (state)
      IDLE:     if (frame_start) state_nxt = LOAD;
      LOAD: begin
        mem_rd = 1'b1;
        if (last_row) state_nxt = WAIT_RDY;
      end
      WAIT_RDY: if (ready) state_nxt = START;
      START: begin
        start     = 1'b1;
        state_nxt = (issue_cnt + ISSUE_W'(1) < ISSUE_MAX) ? LOAD : DRAIN;
      end
      DRAIN:    if (frame_full) state_nxt = DONE;
      DONE: begin
        frame_done = 1'b1;
        state_nxt  = IDLE;
      end
      default:  state_nxt = IDLE;
    endcase
  end

  // Row fetch: data returns one cycle after mem_rd, so din_valid and wa are the read strobe delayed.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      mem_addr  <= '0;
      row_cnt   <= '0;
      issue_cnt <= '0;
      din_valid <= 1'b0;
      wa        <= '0;
    end else begin
      din_valid <= mem_rd;
      if (mem_rd) wa <= 3'(row_cnt);
      if (frame_clr) begin
        mem_addr  <= '0;
        row_cnt   <= '0;
        issue_cnt <= '0;
      end else begin
        if (mem_rd) begin
          mem_addr <= mem_addr + ADDR_W'(1);
          row_cnt  <= last_row ? '0 : row_cnt + ROW_IDX_W'(1);
        end
        if (start) issue_cnt <= issue_cnt + ISSUE_W'(1);
      end
    end
  end

  assign di = din_valid ? mem_rdata : '0;

  dctq_coef_stage #(
    .NUM_BLKS (NUM_BLKS),
    .COEF_W   (COEF_W)
  ) u_coef_stage (
    .clk        (clk),
    .reset      (reset),
    .frame_clr  (frame_clr),
    .dctq       (dctq),
    .dctq_valid (dctq_valid),
    .addr       (addr),
    .sink_ready (sink_ready),
    .coef_out   (coef_out),
    .coef_valid (coef_valid),
    .coef_last  (coef_last),
    .hold       (hold),
    .blk_cnt    (blk_cnt),
    .frame_full (frame_full)
`ifdef DCTQ_FRAME_CTRL_NZCNT_EN
    ,
    .nz_cnt     (nz_cnt),
    .nz_valid   (nz_valid)
`endif
  );

endmodule

// File: tb/tb_dctq_frame_ctrl.sv
// Scoreboard bench for dctq_frame_ctrl with NUM_BLKS=2: memory and DCTQ-core models,
// row and coefficient queues, directed frame/stall/backpressure/reset/suppression runs.
module tb_dctq_frame_ctrl;
  localparam int NB     = 2;
  localparam int ROW_W  = 64;
  localparam int ROWS   = 8;
  localparam int COEF_W = 9;
  localparam int ADDR_W = 13;

  logic              clk = 1'b0;
  logic              reset = 1'b1;
  logic              frame_start = 1'b0;
  logic              mem_rd;
  logic [ADDR_W-1:0] mem_addr;
  logic [ROW_W-1:0]  mem_rdata = '0;
  logic [ROW_W-1:0]  di;
  logic              din_valid;
  logic [2:0]        wa;
  logic              ready = 1'b1;
  logic              start;
  logic              hold;
  logic [COEF_W-1:0] dctq = '0;
  logic              dctq_valid = 1'b0;
  logic [5:0]        addr = '0;
  logic [COEF_W-1:0] coef_out;
  logic              coef_valid;
  logic              coef_last;
  logic              sink_ready = 1'b1;
  logic [10:0]       blk_cnt;
  logic              busy;
  logic              frame_done;
`ifdef DCTQ_FRAME_CTRL_NZCNT_EN
  logic [6:0]        nz_cnt;
  logic              nz_valid;
`endif

  always #5 clk = ~clk;

  dctq_frame_ctrl #(
    .NUM_BLKS (NB),
    .ROW_W    (ROW_W),
    .ROWS     (ROWS),
    .COEF_W   (COEF_W),
    .ADDR_W   (ADDR_W)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .frame_start (frame_start),
    .mem_rd      (mem_rd),
    .mem_addr    (mem_addr),
    .mem_rdata   (mem_rdata),
    .di          (di),
    .din_valid   (din_valid),
    .wa          (wa),
    .ready       (ready),
    .start       (start),
    .hold        (hold),
    .dctq        (dctq),
    .dctq_valid  (dctq_valid),
    .addr        (addr),
    .coef_out    (coef_out),
    .coef_valid  (coef_valid),
    .coef_last   (coef_last),
    .sink_ready  (sink_ready),
    .blk_cnt     (blk_cnt),
    .busy        (busy),
    .frame_done  (frame_done)
`ifdef DCTQ_FRAME_CTRL_NZCNT_EN
    ,
    .nz_cnt      (nz_cnt),
    .nz_valid    (nz_valid)
`endif
  );

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  typedef struct packed { logic [COEF_W-1:0] val; logic [5:0] idx; } coef_t;
  typedef struct packed { logic [COEF_W-1:0] val; logic last; } exp_t;
  typedef struct packed { logic [ROW_W-1:0] data; logic [2:0] wa; } row_t;

  logic [ROW_W-1:0]  mem [64];
  coef_t             core_q[$];
  exp_t              exp_q[$];
  row_t              row_q[$];
  coef_t             c_nxt;
  exp_t              e_cur;
  row_t              r_cur;
  int                exp_addr = 0;
  int                lasts = 0;
  int                starts = 0;
  int                accepted = 0;
  int                dones = 0;
  int                nz_run = 0;
  int                nz_expect = 0;
  int                nz_pulses = 0;
  logic              nz_due = 1'b0;
  logic              nz_mode = 1'b0;
  logic              consumed = 1'b1;
  logic              rd_prev = 1'b0;
  logic [ADDR_W-1:0] addr_prev = '0;

  // DCTQ core model: 64 coefficients per start pulse, queued so blocks can overlap.
  task automatic gen_block();
    coef_t c;
    for (int i = 0; i < 64; i++) begin
      c.idx = 6'(i);
      if (nz_mode)
        c.val = (i == 0 || i == 9 || i == 30 || i == 47 || i == 63) ?
                COEF_W'($urandom_range(1, 511)) : '0;
      else
        c.val = COEF_W'($urandom_range(0, 511));
      core_q.push_back(c);
    end
  endtask

  // Bus models drive just after the falling edge; observation happens 1 time unit later.
  always @(negedge clk) begin
    mem_rdata = rd_prev ? mem[addr_prev[5:0]] : '0;
    if (consumed || !dctq_valid) begin
      if (core_q.size() > 0) begin
        c_nxt      = core_q.pop_front();
        dctq       = c_nxt.val;
        addr       = c_nxt.idx;
        dctq_valid = 1'b1;
      end else begin
        dctq_valid = 1'b0;
      end
    end
    #1;
    if (!reset) begin
      if (mem_rd) begin
        check("mem_addr", 64'(mem_addr), 64'(exp_addr));
        row_q.push_back('{mem[exp_addr % 64], 3'(exp_addr % ROWS)});
        exp_addr++;
      end
      if (din_valid) begin
        if (row_q.size() == 0) check("din_unexpected", 1, 0);
        else begin
          r_cur = row_q.pop_front();
          check("di", di, r_cur.data);
          check("wa", 64'(wa), 64'(r_cur.wa));
        end
      end
      if (start) begin
        starts++;
        gen_block();
      end
`ifdef DCTQ_FRAME_CTRL_NZCNT_EN
      if (nz_due) begin
        check("nz_valid", 64'(nz_valid), 1);
        check("nz_cnt", 64'(nz_cnt), 64'(nz_expect));
        nz_due = 1'b0;
      end else if (nz_valid) begin
        check("nz_spurious", 1, 0);
      end
      if (nz_valid) nz_pulses++;
`endif
      if (coef_valid && sink_ready) begin
        accepted++;
        if (exp_q.size() == 0) check("coef_unexpected", 1, 0);
        else begin
          e_cur = exp_q.pop_front();
          check("coef_out", 64'(coef_out), 64'(e_cur.val));
          check("coef_last", 64'(coef_last), 64'(e_cur.last));
          if (e_cur.val != '0) nz_run++;
          if (e_cur.last) begin
            lasts++;
            nz_expect = nz_run;
            nz_run    = 0;
            nz_due    = 1'b1;
          end
        end
      end
      if (dctq_valid && !hold && lasts < NB)
        exp_q.push_back('{dctq, (addr == 6'd63)});
      if (frame_done) dones++;
    end
    rd_prev   = mem_rd;
    addr_prev = mem_addr;
    consumed  = !hold;
  end

  task automatic check_quiet_outputs(input string p);
    check({p, "_mem_rd"}, 64'(mem_rd), 0);
    check({p, "_din_valid"}, 64'(din_valid), 0);
    check({p, "_start"}, 64'(start), 0);
    check({p, "_coef_valid"}, 64'(coef_valid), 0);
    check({p, "_coef_last"}, 64'(coef_last), 0);
    check({p, "_hold"}, 64'(hold), 0);
    check({p, "_busy"}, 64'(busy), 0);
    check({p, "_frame_done"}, 64'(frame_done), 0);
    check({p, "_di"}, di, 0);
    check({p, "_coef_out"}, 64'(coef_out), 0);
    check({p, "_wa"}, 64'(wa), 0);
    check({p, "_mem_addr"}, 64'(mem_addr), 0);
    check({p, "_blk_cnt"}, 64'(blk_cnt), 0);
`ifdef DCTQ_FRAME_CTRL_NZCNT_EN
    check({p, "_nz_valid"}, 64'(nz_valid), 0);
    check({p, "_nz_cnt"}, 64'(nz_cnt), 0);
`endif
  endtask

  task automatic start_frame();
    @(negedge clk);
    exp_addr    = 0;
    lasts       = 0;
    starts      = 0;
    accepted    = 0;
    dones       = 0;
    nz_pulses   = 0;
    frame_start = 1'b1;
    @(negedge clk);
    frame_start = 1'b0;
  endtask

  task automatic run_to_done(input string tag);
    int n = 0;
    while (dones == 0 && n < 2000) begin
      @(negedge clk);
      n++;
    end
    check({tag, "_done_seen"}, 64'(dones != 0), 1);
    @(negedge clk);
    check({tag, "_done_once"}, 64'(dones), 1);
    check({tag, "_blk_cnt"}, 64'(blk_cnt), NB);
    check({tag, "_coefs"}, 64'(accepted), NB * 64);
    check({tag, "_starts"}, 64'(starts), NB);
    check({tag, "_rows"}, 64'(exp_addr), NB * ROWS);
    check({tag, "_leftover"}, 64'(exp_q.size() + row_q.size() + core_q.size()), 0);
    check({tag, "_idle"}, 64'(busy), 0);
  endtask

  task automatic flush_models();
    core_q.delete();
    exp_q.delete();
    row_q.delete();
    nz_run = 0;
    nz_due = 1'b0;
  endtask

  logic [COEF_W-1:0] saved;

  initial begin
    for (int i = 0; i < 64; i++) mem[i] = {$urandom, $urandom};

    repeat (3) @(negedge clk);
    #1 check_quiet_outputs("rst");
    @(negedge clk);
    reset = 1'b0;
    repeat (4) @(negedge clk);
    check("post_rst_idle", 64'(busy), 0);

    // Plain frame with a frame_start pulse while busy that must be ignored.
    start_frame();
    repeat (20) @(negedge clk);
    frame_start = 1'b1;
    @(negedge clk);
    frame_start = 1'b0;
    check("busy_mid_frame", 64'(busy), 1);
    run_to_done("frame");

    // Suppression: extra core output after the frame is full must not reach coef_valid.
    @(posedge clk);
    for (int i = 0; i < 10; i++) core_q.push_back('{COEF_W'(i + 1), 6'(i)});
    repeat (15) begin
      @(negedge clk);
      #1 check("suppressed", 64'(coef_valid), 0);
    end
    check("suppr_drained", 64'(core_q.size()), 0);
    check("suppr_blk_cnt", 64'(blk_cnt), NB);

    // Ready stall after the first block load.
    ready = 1'b0;
    start_frame();
    repeat (28) @(negedge clk);
    check("stall_no_start", 64'(starts), 0);
    check("stall_busy", 64'(busy), 1);
    ready = 1'b1;
    @(negedge clk);
    check("stall_start_pulse", 64'(start), 1);
    @(negedge clk);
    check("stall_start_low", 64'(start), 0);
    run_to_done("stall");

    // Backpressure for 5 cycles while a coefficient is pending.
    start_frame();
    begin
      int n = 0;
      while (!coef_valid && n < 200) begin
        @(negedge clk);
        n++;
      end
      check("bp_valid_seen", 64'(coef_valid), 1);
    end
    sink_ready = 1'b0;
    #1;
    saved = coef_out;
    check("bp_hold", 64'(hold), 1);
    repeat (4) begin
      @(negedge clk);
      #1;
      check("bp_hold", 64'(hold), 1);
      check("bp_valid_kept", 64'(coef_valid), 1);
      check("bp_coef_stable", 64'(coef_out), 64'(saved));
    end
    @(negedge clk);
    sink_ready = 1'b1;
    run_to_done("bp");

    // Reset during the load of block 1, then a clean restart from address 0.
    start_frame();
    begin
      int n = 0;
      while (!(mem_rd && mem_addr >= 8) && n < 200) begin
        @(negedge clk);
        n++;
      end
      check("mid_rst_reached", 64'(mem_rd && mem_addr >= 8), 1);
    end
    reset = 1'b1;
    #1 check_quiet_outputs("mid_rst");
    @(posedge clk);
    flush_models();
    @(negedge clk);
    reset = 1'b0;
    repeat (5) @(negedge clk);
    check("mid_rst_no_resume", 64'(busy), 0);
    check("mid_rst_no_read", 64'(mem_rd), 0);
    start_frame();
    run_to_done("restart");

`ifdef DCTQ_FRAME_CTRL_NZCNT_EN
    // Blocks with exactly five nonzero coefficients.
    nz_mode = 1'b1;
    start_frame();
    run_to_done("nz");
    check("nz_pulses", 64'(nz_pulses), NB);
    check("nz_model_count", 64'(nz_expect), 5);
    nz_mode = 1'b0;
`endif

    repeat (3) @(negedge clk);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, %0d/%0d checks passed", n_pass, n_checks);
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/dctq_frame_ctrl.md
DCTQ_FRAME_CTRL -- requirements
Module: dctq_frame_ctrl

Interface
REQ-001 Parameters (name, default, meaning) SHALL be:
- NUM_BLKS, 1024: blocks per frame.
- ROW_W, 64: bits per block row (8 pixels x 8 bits).
- ROWS, 8: rows per block.
- COEF_W, 9: DCTQ coefficient width.
- ADDR_W, 13: frame-memory row address width.
REQ-002 Ports (name, direction, width, meaning) SHALL be:
- clk, in, 1: single clock; all logic on posedge.
- reset, in, 1: asynchronous, active-high reset.
- frame_start, in, 1: one-cycle pulse that starts a frame; ignored unless idle.
- mem_rd, out, 1: frame-memory read strobe.
- mem_addr, out, ADDR_W: frame-memory row address.
- mem_rdata, in, ROW_W: read data, valid one cycle after mem_rd.
- di, out, ROW_W: row data to the DCTQ core.
- din_valid, out, 1: di is valid.
- wa, out, 3: row index within the block.
- ready, in, 1: DCTQ core can accept start.
- start, out, 1: one-cycle block-start pulse.
- hold, out, 1: stalls the DCTQ core output.
- dctq, in, COEF_W: coefficient from the core.
- dctq_valid, in, 1: dctq is valid.
- addr, in, 6: coefficient index 0..63.
- coef_out, out, COEF_W: forwarded coefficient.
- coef_valid, out, 1: coef_out is valid.
- coef_last, out, 1: asserted on the coefficient with addr==63.
- sink_ready, in, 1: downstream consumer can accept a coefficient.
- blk_cnt, out, 11: number of completed blocks.
- busy, out, 1: frame in progress.
- frame_done, out, 1: one-cycle pulse after the last block completes.

Function
REQ-003 The FSM SHALL have the states IDLE, LOAD, WAIT_RDY, START, DRAIN and DONE.
REQ-004 IDLE SHALL move to LOAD on frame_start, clearing mem_addr, the block-issue counter and blk_cnt.
REQ-005 LOAD SHALL assert mem_rd for ROWS consecutive cycles, incrementing mem_addr once per read.
REQ-006 Each returned row SHALL drive di and din_valid one cycle after its read, with wa counting 0..ROWS-1.
REQ-007 After the last row, LOAD SHALL move to WAIT_RDY; din_valid SHALL be low outside row transfers.
REQ-008 WAIT_RDY SHALL stay until ready=1, then go to START.
REQ-009 START SHALL pulse start for exactly one cycle and increment the issue counter.
REQ-010 START SHALL then go to LOAD if issued<NUM_BLKS, otherwise to DRAIN.
- Loading the next block overlaps output of the current block.
REQ-011 DRAIN SHALL go to DONE when blk_cnt==NUM_BLKS; DONE SHALL pulse frame_done for one cycle and return to IDLE.
REQ-012 The coefficient path SHALL register the core output:
- coef_out<=dctq, coef_valid<=dctq_valid, coef_last<=(dctq_valid && addr==63).
- Latency: 1 cycle.
REQ-013 Backpressure SHALL be combinational: hold = coef_valid && !sink_ready.
- While hold=1, coef_out, coef_valid and coef_last SHALL be held.
REQ-014 blk_cnt SHALL increment on each accepted coef_last (coef_last && sink_ready).
- It saturates at NUM_BLKS.
REQ-015 Once blk_cnt==NUM_BLKS, further dctq_valid input SHALL be suppressed (coef_valid stays 0) until the next frame_start.
REQ-016 frame_start outside IDLE SHALL be ignored.
REQ-017 mem_addr SHALL wrap modulo 2^ADDR_W.
- If ROWS*NUM_BLKS > 2^ADDR_W the design is illegal; an elaboration check SHALL flag it.
REQ-018 busy SHALL be 1 in every state except IDLE.

Reset
REQ-019 Reset SHALL take effect asynchronously at any time, including mid-frame.
- State goes to IDLE; all counters clear.
- mem_rd, din_valid, start, coef_valid, coef_last, hold, busy and frame_done go to 0.
- di, coef_out, wa and mem_addr go to 0.
REQ-020 After reset deassertion the block SHALL wait in IDLE for a new frame_start; no partial frame resumes.

Configuration
REQ-021 Macro DCTQ_FRAME_CTRL_NZCNT_EN SHALL control a per-block nonzero-coefficient counter.
- Defined: extra outputs nz_cnt (7 bits) and nz_valid (1 bit).
- nz_cnt counts accepted coefficients with coef_out!=0.
- nz_cnt is presented with a one-cycle nz_valid pulse on the cycle after each accepted coef_last, then cleared.
- Undefined: neither port exists and no logic is generated.

Structure
REQ-022 A shared package dctq_pkg SHALL hold:
- the FSM state enum;
- constants BLK_COEFS=64 and LAST_ADDR=63;
- the default NUM_BLKS, ROW_W and COEF_W values.
REQ-023 The coefficient register, hold logic and optional nonzero counter SHALL form one sub-module, dctq_coef_stage.
- The FSM and the memory/row logic stay in the top module.

Verification
REQ-024 The bench SHALL cover at least these directed scenarios (NUM_BLKS=2 unless stated):
- Frame run: ready tied 1, frame_start -> mem_addr 0..15 read, wa 0..7 twice, two start pulses, frame_done after the 2nd addr==63 accepted, blk_cnt=2.
- Ready stall: ready held 0 for 20 cycles after the first load -> start is not asserted until ready rises, then pulses 1 cycle later.
- Backpressure: sink_ready=0 for 5 cycles while coef_valid=1 -> hold=1, coef_out held stable, no coefficient lost or duplicated (64 per block).
- Mid-frame reset: reset asserted during LOAD of block 1 -> all outputs 0 immediately, busy=0; next frame_start restarts at mem_addr 0.
- Suppression: extra dctq_valid after blk_cnt==2 -> coef_valid stays 0; frame_start during busy is ignored.
- With DCTQ_FRAME_CTRL_NZCNT_EN: block with 5 nonzero coefficients -> nz_cnt=5 with a single nz_valid pulse.
